// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: writer FSM states, status bit positions and the keyboard
// device address used by both the keyboard reader and writer.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StShift,
    StAck,
    StWaitIdle
  } ps2_wr_state_e;

  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatDone    = 1;
  localparam int unsigned StatAckErr  = 2;
  localparam int unsigned StatTimeout = 3;
  localparam int unsigned StatOverrun = 4;
  localparam int unsigned StatWidth   = 5;

  localparam logic [7:0] KB_ADDRESS_DEFAULT = 8'b0000_0001;

  // PS/2 frames carry odd parity: the parity bit makes the 9-bit total odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus a falling-edge detector on the
// synchronized value. Resets to the idle (high) level so no edge is seen out of reset.
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fe
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fe    = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_kb_writer.sv
// Memory-mapped PS/2 host-to-device transmitter for the keyboard port. Lines are
// open-drain and released whenever no frame is in progress.
module ps2_kb_writer
  import ps2_pkg::*;
#(
  parameter logic [7:0]  KB_ADDRESS     = KB_ADDRESS_DEFAULT,
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [63:0] ADDRESS,
  input  logic [63:0] WRITE_DATA,
  input  logic        WRITE_EN,
  inout  wire         PS2_KBCLK,
  inout  wire         PS2_KBDAT,
  output logic [63:0] OUT,
  output logic        BUSY
);

  localparam int unsigned MaxCnt = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  ps2_wr_state_e   r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [3:0]      r_idx, w_idx_next;
  logic [8:0]      r_frame, w_frame_next;
  logic            r_done, w_done_next;
  logic            r_ack_err, w_ack_err_next;
  logic            r_timeout, w_timeout_next;
  logic            r_overrun, w_overrun_next;
  logic            r_clk_low, w_clk_low_next;
  logic            r_dat_low, w_dat_low_next;

  logic w_clk_level, w_clk_fe;
  logic w_dat_level, w_dat_fe;
  logic w_dev_sel, w_wr_hit, w_rd_sel;
  logic w_tmo_state;
  logic [StatWidth-1:0] w_status;
  logic w_unused;

  ps2_line_sync u_clk_sync (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_line  (PS2_KBCLK),
    .o_level (w_clk_level),
    .o_fe    (w_clk_fe)
  );

  ps2_line_sync u_dat_sync (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_line  (PS2_KBDAT),
    .o_level (w_dat_level),
    .o_fe    (w_dat_fe)
  );

  assign w_dev_sel = (ADDRESS[63:56] == KB_ADDRESS);
  assign w_wr_hit  = WRITE_EN & w_dev_sel & ~ADDRESS[0];
  assign w_rd_sel  = w_dev_sel & ADDRESS[0];
  assign w_unused  = ^{WRITE_DATA[63:8], ADDRESS[55:1], w_dat_fe};

  assign w_tmo_state = (r_state == StShift) || (r_state == StAck) || (r_state == StWaitIdle);

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_frame_next   = r_frame;
    w_done_next    = r_done;
    w_ack_err_next = r_ack_err;
    w_timeout_next = r_timeout;
    w_overrun_next = r_overrun;
    w_clk_low_next = 1'b0;
    w_dat_low_next = 1'b0;

    if (w_wr_hit && (r_state != StIdle)) begin
      w_overrun_next = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (w_wr_hit) begin
          w_state_next   = StInhibit;
          w_frame_next   = {odd_parity(WRITE_DATA[7:0]), WRITE_DATA[7:0]};
          w_cnt_next     = '0;
          w_done_next    = 1'b0;
          w_ack_err_next = 1'b0;
          w_timeout_next = 1'b0;
          w_overrun_next = 1'b0;
          w_clk_low_next = 1'b1;
          w_dat_low_next = 1'b1;
        end
      end

      StInhibit: begin
        // Data stays low through the release: it doubles as the start bit.
        w_dat_low_next = 1'b1;
        if (r_cnt == InhibitLast) begin
          w_state_next = StShift;
          w_cnt_next   = '0;
          w_idx_next   = '0;
        end else begin
          w_cnt_next     = r_cnt + CntW'(1);
          w_clk_low_next = 1'b1;
        end
      end

      StShift: begin
        w_dat_low_next = r_dat_low;
        w_cnt_next     = r_cnt + CntW'(1);
        if (w_clk_fe) begin
          w_cnt_next = '0;
          if (r_idx == 4'd9) begin
            w_state_next   = StAck;
            w_dat_low_next = 1'b0;
          end else begin
            // r_idx counts edges seen; edge k puts frame bit k-1 (D0..D7, parity) on the line.
            w_idx_next     = r_idx + 4'd1;
            w_dat_low_next = ~r_frame[r_idx];
          end
        end
      end

      StAck: begin
        w_cnt_next = w_clk_fe ? '0 : r_cnt + CntW'(1);
        if (w_clk_fe) begin
          w_ack_err_next = w_dat_level;
          w_state_next   = StWaitIdle;
        end
      end

      StWaitIdle: begin
        w_cnt_next = w_clk_fe ? '0 : r_cnt + CntW'(1);
        if (w_clk_level && w_dat_level) begin
          w_done_next  = 1'b1;
          w_state_next = StIdle;
        end
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase

    // A stalled keyboard abandons the frame without reporting completion.
    if (w_tmo_state && !w_clk_fe && (r_cnt == TimeoutLast) && (w_state_next != StIdle)) begin
      w_state_next   = StIdle;
      w_timeout_next = 1'b1;
      w_done_next    = 1'b0;
      w_clk_low_next = 1'b0;
      w_dat_low_next = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_frame   <= '0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
      r_clk_low <= 1'b0;
      r_dat_low <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_frame   <= w_frame_next;
      r_done    <= w_done_next;
      r_ack_err <= w_ack_err_next;
      r_timeout <= w_timeout_next;
      r_overrun <= w_overrun_next;
      r_clk_low <= w_clk_low_next;
      r_dat_low <= w_dat_low_next;
    end
  end

  assign BUSY = (r_state != StIdle);

  always_comb begin
    w_status              = '0;
    w_status[StatBusy]    = BUSY;
    w_status[StatDone]    = r_done;
    w_status[StatAckErr]  = r_ack_err;
    w_status[StatTimeout] = r_timeout;
    w_status[StatOverrun] = r_overrun;
  end

  assign OUT = w_rd_sel ? {{(64 - StatWidth){1'b0}}, w_status} : {64{1'bz}};

  assign PS2_KBCLK = r_clk_low ? 1'b0 : 1'bz;
  assign PS2_KBDAT = r_dat_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_kb_writer.sv
// Bench for ps2_kb_writer: a keyboard model clocks frames out of the DUT and a
// scenario-level reference predicts received bits and status words.
module tb_ps2_kb_writer;

  localparam int unsigned INH = 50;
  localparam int unsigned TMO = 2000;
  localparam logic [63:0] WR_ADDR    = {8'h01, 56'h0};
  localparam logic [63:0] RD_ADDR    = {8'h01, 55'h0, 1'b1};
  localparam logic [63:0] OTHER_ADDR = {8'h02, 55'h0, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] address = RD_ADDR;
  logic [63:0] write_data = '0;
  logic        write_en = 1'b0;
  logic        busy;
  wire  [63:0] out_bus;
  wire         kb_clk;
  wire         kb_dat;
  logic        m_clk_low = 1'b0;
  logic        m_dat_low = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  assign kb_clk = m_clk_low ? 1'b0 : 1'bz;
  assign kb_dat = m_dat_low ? 1'b0 : 1'bz;
  pullup (kb_clk);
  pullup (kb_dat);

  always #5 clk = ~clk;

  ps2_kb_writer #(
    .KB_ADDRESS     (8'h01),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .ADDRESS    (address),
    .WRITE_DATA (write_data),
    .WRITE_EN   (write_en),
    .PS2_KBCLK  (kb_clk),
    .PS2_KBDAT  (kb_dat),
    .OUT        (out_bus),
    .BUSY       (busy)
  );

  typedef struct {
    logic [7:0]  data;
    bit          clk_en;
    bit          ack;
    logic [9:0]  exp_frame;
    logic [63:0] exp_status;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: frame as seen by the keyboard = D0..D7, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic [9:0] f;
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = (d >> i) & 8'd1;
      ones += int'(f[i]);
    end
    f[8] = (ones % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  function automatic logic [63:0] ref_status(input bit clocked, input bit ack, input bit ovr);
    logic [63:0] s = '0;
    s[1] = clocked;
    s[2] = clocked && !ack;
    s[3] = !clocked;
    s[4] = ovr;
    return s;
  endfunction

  task automatic do_write(input logic [7:0] d);
    @(negedge clk);
    address    = WR_ADDR;
    write_data = {$urandom(), $urandom()};
    write_data[7:0] = d;
    write_en   = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    address  = RD_ADDR;
  endtask

  task automatic read_status(output logic [63:0] s);
    address = RD_ADDR;
    #1;
    s = out_bus;
  endtask

  task automatic kb_pulse(output logic b);
    m_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    m_clk_low = 1'b0;
    #1;
    b = kb_dat;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_release(output int cnt);
    cnt = 0;
    while (kb_clk === 1'b0 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic kb_frame(input bit clk_en, input bit ack, output logic [9:0] rx);
    int   hold;
    logic b;
    rx = '0;
    wait_release(hold);
    check("inhibit_len", 64'(hold), 64'(INH));
    check("start_bit", {63'd0, kb_dat}, 64'd0);
    if (clk_en) begin
      repeat (10) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        kb_pulse(b);
        rx[k] = b;
      end
      m_dat_low = ack;
      repeat (10) @(negedge clk);
      kb_pulse(b);
      m_dat_low = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_clear", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [9:0]  rx;
    logic [63:0] s;
    do_write(v.data);
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    kb_frame(v.clk_en, v.ack, rx);
    if (v.clk_en) begin
      check({tag, "_frame"}, 64'(rx), 64'(v.exp_frame));
      wait_idle();
    end else begin
      repeat (1990) @(negedge clk);
      check({tag, "_busy_pre_tmo"}, {63'd0, busy}, 64'd1);
      repeat (15) @(negedge clk);
      check({tag, "_busy_post_tmo"}, {63'd0, busy}, 64'd0);
      check({tag, "_lines_released"}, {62'd0, kb_clk, kb_dat}, 64'd3);
    end
    read_status(s);
    check({tag, "_status"}, s, v.exp_status);
  endtask

  initial begin
    vec_t        tbl[4];
    vec_t        v;
    logic [9:0]  rx;
    logic [63:0] s;
    logic        b;
    bit          hiz;

    tbl[0] = '{8'hED, 1'b1, 1'b1, 10'h3ED, 64'h02};
    tbl[1] = '{8'hF4, 1'b1, 1'b1, 10'h2F4, 64'h02};
    tbl[2] = '{8'hFF, 1'b1, 1'b0, 10'h3FF, 64'h06};
    tbl[3] = '{8'h55, 1'b0, 1'b0, 10'h000, 64'h08};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    read_status(s);
    check("reset_status", s, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_lines", {62'd0, kb_clk, kb_dat}, 64'd3);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      v.data       = 8'($urandom_range(0, 255));
      v.clk_en     = 1'b1;
      v.ack        = 1'($urandom_range(0, 1));
      v.exp_frame  = ref_frame(v.data);
      v.exp_status = ref_status(1'b1, v.ack, 1'b0);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // Write landing mid-frame: ignored, flagged as overrun.
    do_write(8'hED);
    fork
      kb_frame(1'b1, 1'b1, rx);
      begin
        repeat (200) @(negedge clk);
        do_write(8'hF4);
      end
    join
    check("ovr_frame", 64'(rx), 64'(ref_frame(8'hED)));
    wait_idle();
    read_status(s);
    check("ovr_status", s, ref_status(1'b1, 1'b1, 1'b1));

    address = OTHER_ADDR;
    #1;
    hiz = (out_bus === 64'd0) || (out_bus === {64{1'bz}});
    check("out_hiz_other_dev", {63'd0, hiz}, 64'd1);
    address = WR_ADDR;
    #1;
    hiz = (out_bus === 64'd0) || (out_bus === {64{1'bz}});
    check("out_hiz_write_addr", {63'd0, hiz}, 64'd1);

    // Non-matching device address must not start a frame.
    @(negedge clk);
    address  = {8'h02, 56'h0};
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    address  = RD_ADDR;
    check("foreign_write_busy", {63'd0, busy}, 64'd0);

    // Reset mid-frame while D4 of 0x00 holds data low.
    do_write(8'h00);
    wait_release(s[31:0]);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 5; k++) kb_pulse(b);
    check("pre_reset_data_low", {63'd0, kb_dat}, 64'd0);
    rst = 1'b1;
    #1;
    check("reset_mid_lines", {62'd0, kb_clk, kb_dat}, 64'd3);
    check("reset_mid_busy", {63'd0, busy}, 64'd0);
    read_status(s);
    check("reset_mid_status", s, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset coincident with an accepted write wins.
    @(negedge clk);
    address  = WR_ADDR;
    write_en = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    rst      = 1'b0;
    address  = RD_ADDR;
    @(negedge clk);
    check("reset_vs_write_busy", {63'd0, busy}, 64'd0);
    check("reset_vs_write_clk", {63'd0, kb_clk}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
